// File: rtl/slice_sub12.sv
// Multi-cycle subtractor: a - b - bin computed three bits per clock with borrow
// lookahead inside each slice, behind valid/ready handshakes on both sides.
module slice_sub12 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NS = WIDTH / 3;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic                br_q, br_d;
  logic [NS-1:0][2:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic                bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [2:0] sa, sb, g, p, d;
  logic [3:0] br;

  // Current slice: generate/propagate form of a borrow chain, fully flattened.
  always_comb begin
    sa    = a_q[k_q];
    sb    = b_q[k_q];
    g     = ~sa & sb;
    p     = ~(sa ^ sb);
    br[0] = br_q;
    br[1] = g[0] | (p[0] & br[0]);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br[0]);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br[0]);
    d     = sa ^ sb ^ br[2:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[k_q] = d;
        br_d        = br[3];
        k_d         = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
          bout_d  = br[3];
          // Slice NS-1 is the one being written, so d[2] is the result MSB.
          ovf_d   = (a_q[NS-1][2] != b_q[NS-1][2]) & (d[2] != a_q[NS-1][2]);
          zero_d  = (diff_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_slice_sub12.sv
// Self-checking bench for slice_sub12 at WIDTH=12: directed corner cases plus
// randomized handshakes checked against an integer-arithmetic reference.
module tb_slice_sub12;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a, b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] diff;
  logic        bout, ovf, zero;

  int n_checks = 0;
  int n_fail   = 0;

  slice_sub12 #(.WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } exp_t;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [11:0] ma, input logic [11:0] mb, input logic mbin);
    exp_t e;
    int ua, ub, sa, sb, r;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua >= 2048) ? ua - 4096 : ua;
    sb = (ub >= 2048) ? ub - 4096 : ub;
    r  = sa - sb - int'(mbin);
    e.d  = 12'((ua - ub - int'(mbin)) & 4095);
    e.bo = (ua < ub + int'(mbin));
    e.ov = (ma[11] != mb[11]) && (r < -2048 || r > 2047);
    e.z  = (e.d == 12'h000);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation to completion; returns raw outputs and measured latency.
  task automatic run_op(input logic [11:0] ta, input logic [11:0] tb, input logic tbin,
                        output logic [11:0] od, output logic obo, output logic oov,
                        output logic oz, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 12'($urandom); b = 12'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    od = diff; obo = bout; oov = ovf; oz = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 12'h123; b = 12'h001; bin = 1'b0;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (diff !== 12'h000 || bout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: diff=%h bout=%b ovf=%b zero=%b required 000/0/0/0", diff, bout, ovf, zero);
    end
    in_valid = 1'b0; rst = 1'b0;
    tick();
    $display("reset: in_ready=%b out_valid=%b diff=%h", in_ready, out_valid, diff);
  endtask

  task automatic test_directed(input string name, input logic [11:0] ta, input logic [11:0] tb,
                               input logic tbin, input logic [11:0] rd, input logic rbo,
                               input logic rov, input logic rz);
    logic [11:0] od; logic obo, oov, oz; int lat;
    run_op(ta, tb, tbin, od, obo, oov, oz, lat);
    $display("%s: a=%h b=%h bin=%b -> diff=%h bout=%b ovf=%b zero=%b lat=%0d",
             name, ta, tb, tbin, od, obo, oov, oz, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d required 4", name, lat);
    end
    n_checks++;
    if ({od, obo, oov, oz} !== {rd, rbo, rov, rz}) begin
      n_fail++;
      $display("FAIL %s_result: diff=%h bout=%b ovf=%b zero=%b required %h/%b/%b/%b",
               name, od, obo, oov, oz, rd, rbo, rov, rz);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_return_idle: in_ready=%b required 1", name, in_ready);
    end
  endtask

  task automatic test_hold();
    int guard;
    a = 12'h005; b = 12'h002; bin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 12'($urandom); b = 12'($urandom); bin = 1'($urandom);
      tick();
      n_checks++;
      if (diff !== 12'h002 || out_valid !== 1'b1 || in_ready !== 1'b0 || bout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_%0d: diff=%h out_valid=%b in_ready=%b bout=%b required 002/1/0/0",
                 i, diff, out_valid, in_ready, bout);
      end
      $display("hold cycle %0d: diff=%h out_valid=%b in_ready=%b", i, diff, out_valid, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    a = 12'h555; b = 12'h111; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midrun_no_result: out_valid seen %0d times required 0", seen);
    end
    $display("reset mid-run: in_ready=%b stray out_valid=%0d", in_ready, seen);
    test_directed("after_reset", 12'h00A, 12'h003, 1'b0, 12'h007, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int   cyc, done_cnt;
    logic acc, rel;
    cyc = 0; done_cnt = 0;
    while (done_cnt < 1000 && cyc < 60000) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      a = 12'($urandom); b = 12'($urandom); bin = 1'($urandom);
      acc = in_valid && in_ready;
      rel = out_valid && out_ready;
      if (acc) q.push_back(model(a, b, bin));
      if (rel) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: result diff=%h with no pending operation", diff);
        end else begin
          e = q.pop_front();
          if ({diff, bout, ovf, zero} !== {e.d, e.bo, e.ov, e.z}) begin
            n_fail++;
            $display("FAIL b2b_%0d: diff=%h bout=%b ovf=%b zero=%b required %h/%b/%b/%b",
                     done_cnt, diff, bout, ovf, zero, e.d, e.bo, e.ov, e.z);
          end
          $display("b2b %0d: diff=%h bout=%b ovf=%b zero=%b", done_cnt, diff, bout, ovf, zero);
        end
        done_cnt++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (done_cnt < 1000) begin
      n_fail++;
      $display("FAIL b2b_timeout: completed %0d required 1000", done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    test_reset();
    test_directed("ovf",      12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1, 1'b0);
    test_directed("ripple",   12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0);
    test_directed("equal",    12'h123, 12'h123, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    test_directed("equal_bin",12'h123, 12'h123, 1'b1, 12'hFFF, 1'b1, 1'b0, 1'b0);
    test_directed("pos_ovf",  12'h7FF, 12'hFFF, 1'b1, 12'h7FF, 1'b1, 1'b0, 1'b0);
    test_directed("neg_ovf",  12'h7FF, 12'h800, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b0);
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_sub12.md
SLICE_SUB12 -- requirements
Module: slice_sub12

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 12, operand width in bits; it must be a multiple of 3, in the range 3..30.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port bin, input, 1 bit: borrow-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-012 The block SHALL have port bout, output, 1 bit: borrow-out, equal to 1 iff a < b + bin (unsigned).
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement overflow.
REQ-014 The block SHALL have port zero, output, 1 bit: diff equals 0.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE, and SHALL hold a slice counter k ranging 0..WIDTH/3-1.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be decoded from registered state.
REQ-017 In IDLE, when in_valid=1 at a rising edge: a, b and bin SHALL be captured, the borrow register SHALL be loaded with bin, k SHALL be set to 0, and the next state SHALL be RUN.
REQ-018 In RUN, each cycle SHALL process slice k (bits 3k+2..3k) using 3-bit borrow lookahead with the following definitions:
- g[i] = ~a[i] & b[i]
- p[i] = ~(a[i] ^ b[i])
- br[i+1] = g[i] | (p[i] & br[i]), with br[0] = the borrow register
- d[i] = a[i] ^ b[i] ^ br[i]
REQ-019 At each RUN edge, the 3 difference bits SHALL be written into diff[3k+2:3k], br[3] SHALL be written to the borrow register, and k SHALL increment.
REQ-020 At the RUN edge where k = WIDTH/3-1, the following SHALL occur:
- state goes to DONE
- bout = br[3]
- ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB])
- zero = 1 iff the full diff is 0
REQ-021 Latency SHALL be WIDTH/3 cycles from the accepting edge to out_valid=1 (4 cycles at the default width).
REQ-022 In DONE, diff, bout, ovf and zero SHALL remain stable while out_ready=0.
REQ-023 In DONE with out_ready=1, the block SHALL go to IDLE at that edge; it SHALL NOT accept new operands on the same edge, giving a throughput of one operation per WIDTH/3+2 cycles.
REQ-024 Changes on a, b and bin outside the accepting edge SHALL NOT affect the result.
REQ-025 in_valid in RUN or DONE SHALL be ignored.
REQ-026 diff bits of slices not yet processed SHALL be don't-care until out_valid=1.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL reset as follows:
- state = IDLE, k = 0, borrow register = 0
- diff = 0, bout = 0, ovf = 0, zero = 0
- in_ready = 1, out_valid = 0
REQ-028 rst SHALL take priority over every other input, including in_valid at the same edge.
REQ-029 Reset during RUN or DONE SHALL discard the operation in progress, and no out_valid SHALL appear for it.

Verification
REQ-030 The bench SHALL cover the following directed scenarios (WIDTH=12):
- a=0x800, b=0x001, bin=0 -> diff=0x7FF, bout=0, ovf=1, zero=0, out_valid exactly 4 cycles after accept.
- a=0x000, b=0x001, bin=0 -> diff=0xFFF, bout=1, ovf=0, zero=0 (borrow ripples through all 4 slices).
- a=0x123, b=0x123, bin=0 -> diff=0x000, bout=0, zero=1; same operands with bin=1 -> diff=0xFFF, bout=1.
- a=0x005, b=0x002, bin=1, out_ready held 0 for 3 cycles -> diff=0x002 held stable; in_ready stays 0; in_valid pulses are ignored.
- rst asserted on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0; a following a=0x00A, b=0x003 -> diff=0x007.
- Random back-to-back: 1000 operand sets with random in_valid and out_ready -> all results match a - b - bin mod 4096, with bout and ovf checked against a reference model.
